// File: rtl/xlr8_dm_initiator.sv
// rtl/xlr8_dm_initiator.sv - queued data-memory bus initiator for XLR8 XB register interfaces
module xlr8_dm_initiator #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clken,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [7:0]            rsp_rdata,
  output logic                  rsp_err,
  output logic                  dm_sel,
  output logic [ADDR_WIDTH-1:0] ramadr,
  output logic                  ramwe,
  output logic                  ramre,
  output logic [7:0]            dbus_wr,
  input  logic [7:0]            dbus_rd,
  input  logic                  io_out_en,
  output logic                  busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT);

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            wdata;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t          state;
  cmd_t            mem [DEPTH];
  cmd_t            head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [TW-1:0]   to_cnt;
  logic            push;
  logic            pop;

  // Gating with rst keeps the port closed while the FIFO is being flushed.
  assign cmd_ready = !rst && (count != FULL_CNT);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && (count != '0);
  assign head      = mem[rd_ptr];
  assign busy      = (state != IDLE) || (count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dm_sel    <= 1'b0;
      ramadr    <= '0;
      ramwe     <= 1'b0;
      ramre     <= 1'b0;
      dbus_wr   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      to_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            dm_sel <= 1'b1;
            ramadr <= head.addr;
            to_cnt <= '0;
            if (head.write) begin
              ramwe   <= 1'b1;
              dbus_wr <= head.wdata;
              state   <= WRITE;
            end else begin
              ramre <= 1'b1;
              state <= READ;
            end
          end
        end
        WRITE: begin
          if (clken) begin
            dm_sel  <= 1'b0;
            ramadr  <= '0;
            ramwe   <= 1'b0;
            dbus_wr <= '0;
            state   <= IDLE;
          end
        end
        READ: begin
          // Only clken cycles count: the responder cannot complete on a gated edge.
          if (clken) begin
            if (io_out_en) begin
              rsp_rdata <= dbus_rd;
              rsp_err   <= 1'b0;
              rsp_valid <= 1'b1;
              dm_sel    <= 1'b0;
              ramadr    <= '0;
              ramre     <= 1'b0;
              state     <= RESP;
            end else begin
              to_cnt <= to_cnt + 1'b1;
              if (to_cnt + 1'b1 == TO_LAST) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
                rsp_valid <= 1'b1;
                dm_sel    <= 1'b0;
                ramadr    <= '0;
                ramre     <= 1'b0;
                state     <= RESP;
              end
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
